knn_ctrl: RTL and testbench

KNN_CTRL -- requirements
Module: knn_ctrl

---
 rtl/knn_pkg.sv | 19 +
 rtl/knn_core.sv | 30 +++
 rtl/knn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_knn_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
`default_nettype none
// knn_pkg -- FSM encoding and default sizing shared by the KNN search controller. Rev 1.0
package knn_pkg;

  localparam int KNN_K_DEF       = 4;
  localparam int KNN_N_MAX_DEF   = 64;
  localparam int KNN_LABEL_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_CALC   = 3'd2,
    ST_INSERT = 3'd3,
    ST_VOTE   = 3'd4,
    ST_DONE   = 3'd5
  } knn_state_t;

endpackage
`default_nettype wire

// File: rtl/knn_core.sv
`default_nettype none
// knn_core -- squared Euclidean distance between the test point and one dataset point. Rev 1.0
module knn_core
  import knn_pkg::*;
#(
  parameter int KNN_WDATA_W = 32
) (
  input  logic signed [KNN_WDATA_W-1:0]   tx,
  input  logic signed [KNN_WDATA_W-1:0]   ty,
  input  logic signed [KNN_WDATA_W-1:0]   px,
  input  logic signed [KNN_WDATA_W-1:0]   py,
  output logic        [2*KNN_WDATA_W-1:0] d2
);

  localparam int DW = 2 * KNN_WDATA_W;

  logic signed [KNN_WDATA_W:0] dx;
  logic signed [KNN_WDATA_W:0] dy;
  logic signed [DW-1:0]        dx_ext;
  logic signed [DW-1:0]        dy_ext;

  // One extra bit keeps the difference exact; the squares are taken modulo 2^DW.
  assign dx     = (KNN_WDATA_W+1)'(tx) - (KNN_WDATA_W+1)'(px);
  assign dy     = (KNN_WDATA_W+1)'(ty) - (KNN_WDATA_W+1)'(py);
  assign dx_ext = DW'(dx);
  assign dy_ext = DW'(dy);
  assign d2     = $unsigned(dx_ext * dx_ext + dy_ext * dy_ext);

endmodule
`default_nettype wire

// File: rtl/knn_ctrl.sv
`default_nettype none
// knn_ctrl -- k-nearest-neighbour search over an external dataset with a sorted K-slot list.
// Rev 1.0. Optional majority vote enabled by defining KNN_VOTE_EN.
module knn_ctrl
  import knn_pkg::*;
#(
  parameter  int KNN_WDATA_W = 32,
  parameter  int K           = KNN_K_DEF,
  parameter  int N_MAX       = KNN_N_MAX_DEF,
  parameter  int LABEL_W     = KNN_LABEL_W_DEF,
  localparam int ADDR_W      = $clog2(N_MAX),
  localparam int DW          = 2 * KNN_WDATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W:0]               n_points,
  input  logic signed [KNN_WDATA_W-1:0] tx,
  input  logic signed [KNN_WDATA_W-1:0] ty,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic signed [KNN_WDATA_W-1:0] mem_x,
  input  logic signed [KNN_WDATA_W-1:0] mem_y,
  input  logic [LABEL_W-1:0]            mem_label,
  output logic                          busy,
  output logic                          done,
  output logic [K-1:0]                  nbr_valid,
  output logic [K*DW-1:0]               nbr_dist,
  output logic [K*LABEL_W-1:0]          nbr_label,
  output logic [LABEL_W-1:0]            vote_label
);

  localparam logic [ADDR_W:0] NMAX_C = (ADDR_W+1)'(N_MAX);
  localparam logic [ADDR_W:0] NP_ONE = (ADDR_W+1)'(1);

  knn_state_t state, state_nxt;

  logic [ADDR_W-1:0]                idx, n_last;
  logic signed [KNN_WDATA_W-1:0]    tx_q, ty_q;
  logic [DW-1:0]                    d2_w, d2_q;
  logic [LABEL_W-1:0]               lab_q;
  logic [K-1:0]                     valid_q, valid_nxt, gt;
  logic [K-1:0][DW-1:0]             dist_q, dist_nxt;
  logic [K-1:0][LABEL_W-1:0]        slab_q, slab_nxt;
  logic                             last;

  assign last = (idx == n_last);

  knn_core #(.KNN_WDATA_W(KNN_WDATA_W)) u_core (
    .tx (tx_q),
    .ty (ty_q),
    .px (mem_x),
    .py (mem_y),
    .d2 (d2_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_en    = 1'b0;
    mem_addr  = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (n_points == '0) ? ST_VOTE : ST_FETCH;
      end
      ST_FETCH: begin
        mem_en    = 1'b1;
        mem_addr  = idx;
        state_nxt = ST_CALC;
      end
      ST_CALC:   state_nxt = ST_INSERT;
      ST_INSERT: state_nxt = last ? ST_VOTE : ST_FETCH;
      ST_VOTE:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The list stays sorted with invalid slots at the tail, so gt is a thermometer code
  // and its first set bit is the insertion point; strict '>' keeps ties stable.
  for (genvar i = 0; i < K; i++) begin : g_slot
    assign gt[i] = !valid_q[i] || (dist_q[i] > d2_q);
    if (i == 0) begin : g_head
      assign dist_nxt[i]  = gt[i] ? d2_q  : dist_q[i];
      assign slab_nxt[i]  = gt[i] ? lab_q : slab_q[i];
      assign valid_nxt[i] = 1'b1;
    end else begin : g_tail
      assign dist_nxt[i]  = !gt[i] ? dist_q[i]  : (!gt[i-1] ? d2_q  : dist_q[i-1]);
      assign slab_nxt[i]  = !gt[i] ? slab_q[i]  : (!gt[i-1] ? lab_q : slab_q[i-1]);
      assign valid_nxt[i] = !gt[i] ? valid_q[i] : (!gt[i-1] ? 1'b1  : valid_q[i-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      n_last  <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      d2_q    <= '0;
      lab_q   <= '0;
      valid_q <= '0;
      dist_q  <= '0;
      slab_q  <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_q    <= tx;
            ty_q    <= ty;
            idx     <= '0;
            n_last  <= (n_points > NMAX_C) ? ADDR_W'(N_MAX - 1) : ADDR_W'(n_points - NP_ONE);
            valid_q <= '0;
            dist_q  <= '0;
            slab_q  <= '0;
          end
        end
        ST_CALC: begin
          d2_q  <= d2_w;
          lab_q <= mem_label;
        end
        ST_INSERT: begin
          valid_q <= valid_nxt;
          dist_q  <= dist_nxt;
          slab_q  <= slab_nxt;
          if (!last) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
      done <= (state == ST_DONE);
    end
  end

  assign nbr_valid = valid_q;
  assign nbr_dist  = dist_q;
  assign nbr_label = slab_q;

`ifdef KNN_VOTE_EN
  localparam int CW = $clog2(K + 1);

  logic [LABEL_W-1:0] vote_w, vote_q;
  logic [CW-1:0]      cnt, best;

  // Scanning nearest-first with strict '>' hands ties to the lowest-index slot.
  always_comb begin
    vote_w = '0;
    best   = '0;
    cnt    = '0;
    for (int i = 0; i < K; i++) begin
      cnt = '0;
      for (int j = 0; j < K; j++)
        if (valid_q[j] && (slab_q[j] == slab_q[i])) cnt = cnt + CW'(1);
      if (valid_q[i] && (cnt > best)) begin
        best   = cnt;
        vote_w = slab_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  vote_q <= '0;
    else if (state == ST_VOTE) vote_q <= vote_w;
  end

  assign vote_label = vote_q;
`else
  assign vote_label = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_knn_ctrl.sv
`default_nettype none
// tb_knn_ctrl -- randomized and directed checks of knn_ctrl against a sort-based reference model.
module tb_knn_ctrl;

  localparam int W     = 32;
  localparam int K     = 4;
  localparam int N_MAX = 64;
  localparam int LW    = 8;
  localparam int AW    = $clog2(N_MAX);
  localparam int DW    = 2 * W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AW:0]          n_points;
  logic signed [W-1:0]  tx, ty, mem_x, mem_y;
  logic [LW-1:0]        mem_label;
  logic                 mem_en, busy, done;
  logic [AW-1:0]        mem_addr;
  logic [K-1:0]         nbr_valid;
  logic [K*DW-1:0]      nbr_dist;
  logic [K*LW-1:0]      nbr_label;
  logic [LW-1:0]        vote_label;

  always #5 clk = ~clk;

  knn_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_points   (n_points),
    .tx         (tx),
    .ty         (ty),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_x      (mem_x),
    .mem_y      (mem_y),
    .mem_label  (mem_label),
    .busy       (busy),
    .done       (done),
    .nbr_valid  (nbr_valid),
    .nbr_dist   (nbr_dist),
    .nbr_label  (nbr_label),
    .vote_label (vote_label)
  );

  // Dataset memory: one-cycle read latency.
  logic signed [W-1:0] mx [N_MAX];
  logic signed [W-1:0] my [N_MAX];
  logic [LW-1:0]       ml [N_MAX];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_x     <= mx[mem_addr];
      mem_y     <= my[mem_addr];
      mem_label <= ml[mem_addr];
    end
  end

  int checks, failures;
  int tcnt, done_t, exp_n;
  bit run_active, mode_zero;
  logic [K-1:0]          exp_valid;
  logic [K-1:0][DW-1:0]  exp_dist;
  logic [K-1:0][LW-1:0]  exp_lab;
  logic [LW-1:0]         exp_vote;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full stable selection sort over every point, keep the first K.
  task automatic build_model(input int n, input longint x0, input longint y0);
    longint d [N_MAX];
    bit     used [N_MAX];
    int     ne, best;
    int     lab_cnt [1 << LW];
    int     bc;
    ne = (n > N_MAX) ? N_MAX : n;
    exp_n = ne;
    exp_valid = '0;
    exp_dist  = '0;
    exp_lab   = '0;
    for (int i = 0; i < ne; i++) begin
      d[i] = (x0 - longint'(mx[i])) * (x0 - longint'(mx[i])) +
             (y0 - longint'(my[i])) * (y0 - longint'(my[i]));
      used[i] = 1'b0;
    end
    for (int s = 0; s < K; s++) begin
      if (s < ne) begin
        best = -1;
        for (int i = 0; i < ne; i++)
          if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
        used[best]   = 1'b1;
        exp_valid[s] = 1'b1;
        exp_dist[s]  = DW'(d[best]);
        exp_lab[s]   = ml[best];
      end
    end
    exp_vote = '0;
`ifdef KNN_VOTE_EN
    for (int l = 0; l < (1 << LW); l++) lab_cnt[l] = 0;
    for (int s = 0; s < K; s++) if (exp_valid[s]) lab_cnt[exp_lab[s]]++;
    bc = 0;
    for (int s = 0; s < K; s++)
      if (exp_valid[s] && lab_cnt[exp_lab[s]] > bc) begin
        bc       = lab_cnt[exp_lab[s]];
        exp_vote = exp_lab[s];
      end
`else
    lab_cnt[0] = 0;
    bc = lab_cnt[0];
`endif
  endtask

  // Per-cycle compare against the timeline implied by the model.
  always @(negedge clk) begin
    int t, c;
    logic [K-1:0] ev;
    if (mode_zero) begin
      chk("rst_busy",   busy,       '0);
      chk("rst_done",   done,       '0);
      chk("rst_mem_en", mem_en,     '0);
      chk("rst_addr",   mem_addr,   '0);
      chk("rst_valid",  nbr_valid,  '0);
      chk("rst_dist",   nbr_dist,   '0);
      chk("rst_label",  nbr_label,  '0);
      chk("rst_vote",   vote_label, '0);
    end else if (run_active) begin
      t = tcnt;
      chk("busy",     busy,     t <= 3*exp_n + 1);
      chk("done",     done,     t == 3*exp_n + 2);
      chk("mem_en",   mem_en,   (t < 3*exp_n) && (t % 3 == 0));
      chk("mem_addr", mem_addr, ((t < 3*exp_n) && (t % 3 == 0)) ? t/3 : 0);
      c = t / 3;
      if (c > exp_n) c = exp_n;
      if (c > K) c = K;
      ev = '0;
      for (int i = 0; i < c; i++) ev[i] = 1'b1;
      chk("nbr_valid", nbr_valid, ev);
      if (t >= 3*exp_n) begin
        chk("nbr_dist",  nbr_dist,  exp_dist);
        chk("nbr_label", nbr_label, exp_lab);
      end
      if (t >= 3*exp_n + 2) chk("vote_label", vote_label, exp_vote);
    end
  end

  task automatic do_search(input int n, input int x0, input int y0,
                           input int poke, input int abort_at, input bit rel_rst);
    int lim;
    @(negedge clk);
    if (rel_rst) rst = 1'b1;
    start    = 1'b1;
    n_points = (AW+1)'(n);
    tx       = x0;
    ty       = y0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n_points = (AW+1)'($urandom);
    tx       = $urandom;
    ty       = $urandom;
    build_model(n, x0, y0);
    tcnt       = 0;
    done_t     = -1;
    mode_zero  = 1'b0;
    run_active = 1'b1;
    lim = 3*exp_n + 4;
    while (tcnt < lim) begin
      @(posedge clk);
      tcnt++;
      #1;
      if (done && done_t < 0) done_t = tcnt;
      if (poke != 0 && tcnt == poke) begin
        start = 1'b1; n_points = 1; tx = 99; ty = -99;
      end else begin
        start = 1'b0;
      end
      if (tcnt == abort_at) begin
        #1;
        rst        = 1'b0;
        run_active = 1'b0;
        mode_zero  = 1'b1;
        #1;
        chk("abort_busy",  busy,       '0);
        chk("abort_done",  done,       '0);
        chk("abort_memen", mem_en,     '0);
        chk("abort_addr",  mem_addr,   '0);
        chk("abort_valid", nbr_valid,  '0);
        chk("abort_dist",  nbr_dist,   '0);
        chk("abort_label", nbr_label,  '0);
        chk("abort_vote",  vote_label, '0);
        break;
      end
    end
  endtask

  task automatic set_pt(input int i, input int x, input int y, input int l);
    mx[i] = x; my[i] = y; ml[i] = LW'(l);
  endtask

  task automatic rand_points(input int n);
    for (int i = 0; i < n; i++)
      set_pt(i, int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
             int'($urandom_range(0, 3)));
  endtask

  logic [K-1:0][DW-1:0] lit_d;
  logic [K-1:0][LW-1:0] lit_l;

  initial begin
    checks = 0; failures = 0; tcnt = 0; done_t = -1; exp_n = 0;
    rst = 1'b0; start = 1'b0; n_points = '0; tx = '0; ty = '0;
    mode_zero = 1'b1; run_active = 1'b0;
    for (int i = 0; i < N_MAX; i++) set_pt(i, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic five-point search
    set_pt(0, 3, 4, 1); set_pt(1, 1, 1, 2); set_pt(2, -2, 0, 3);
    set_pt(3, 5, 5, 4); set_pt(4, 0, 1, 5);
    do_search(5, 0, 0, 0, -1, 1'b0);
    lit_d[0] = 1; lit_d[1] = 2; lit_d[2] = 4; lit_d[3] = 25;
    lit_l[0] = 5; lit_l[1] = 2; lit_l[2] = 3; lit_l[3] = 1;
    chk("t1_model_dist", exp_dist,  lit_d);
    chk("t1_dist",       nbr_dist,  lit_d);
    chk("t1_label",      nbr_label, lit_l);
    chk("t1_done_cycle", done_t,    17);

    // Empty dataset
    do_search(0, 3, 3, 0, -1, 1'b0);
    chk("t2_done_cycle", done_t,     2);
    chk("t2_valid",      nbr_valid,  '0);
    chk("t2_vote",       vote_label, '0);

    // Equal distances keep dataset order
    set_pt(0, 1, 0, 7); set_pt(1, 0, 1, 8); set_pt(2, -1, 0, 9);
    do_search(3, 0, 0, 0, -1, 1'b0);
    lit_l[0] = 7; lit_l[1] = 8; lit_l[2] = 9; lit_l[3] = 0;
    chk("t3_label", nbr_label, lit_l);
    chk("t3_valid", nbr_valid, 4'b0111);

    // Start while busy is ignored
    set_pt(0, 3, 4, 1); set_pt(1, 1, 1, 2); set_pt(2, -2, 0, 3);
    set_pt(3, 5, 5, 4); set_pt(4, 0, 1, 5);
    do_search(5, 0, 0, 4, -1, 1'b0);
    lit_l[0] = 5; lit_l[1] = 2; lit_l[2] = 3; lit_l[3] = 1;
    chk("t4_dist",       nbr_dist,  lit_d);
    chk("t4_label",      nbr_label, lit_l);
    chk("t4_done_cycle", done_t,    17);

    // Reset during INSERT of point 3, then a fresh search right after release
    rand_points(6);
    do_search(6, 5, -5, 0, 3*3 + 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_t, -1);
    rand_points(9);
    do_search(9, -7, 12, 0, -1, 1'b1);

    // Majority vote
    set_pt(0, 1, 0, 2); set_pt(1, 1, 1, 5); set_pt(2, 2, 0, 2); set_pt(3, 2, 1, 5);
    do_search(4, 0, 0, 0, -1, 1'b0);
`ifdef KNN_VOTE_EN
    chk("t6_model_vote", exp_vote,   2);
    chk("t6_vote",       vote_label, 2);
`else
    chk("t6_model_vote", exp_vote,   0);
    chk("t6_vote",       vote_label, 0);
`endif

    // Randomized searches
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      rand_points(n);
      do_search(n, int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
                (r % 2 == 1) ? 7 : 0, -1, 1'b0);
    end

    // Oversized count saturates to N_MAX
    rand_points(N_MAX);
    do_search(100, 3, -2, 0, -1, 1'b0);
    chk("t7_done_cycle", done_t, 3*N_MAX + 2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
